// File: rtl/power_avg_pkg.sv
// power_avg_pkg
//   Shared types and width helpers for the spectral power averager.
//   - state_t      : framing state machine encoding
//   - acc_width()  : accumulator width, 2*W_DATA + LOG_AVG (never saturates)
//   - cnt_width()  : counter width for a modulus n, at least 1 bit
package power_avg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic int acc_width(input int w_data, input int log_avg);
    return 2 * w_data + log_avg;
  endfunction

  // A modulus of 1 (LOG_AVG = 0) still needs a 1-bit register that stays 0.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/power_avg_sdp_ram.sv
// power_avg_sdp_ram
//   Simple dual-port RAM holding one running power sum per FFT bin.
//   No reset: every location is overwritten by the first frame of each
//   averaging run before it is ever read back.
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe
//   rd_addr  in   read address
//   rd_data  out  registered read data, valid the cycle after rd_en
module power_avg_sdp_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 34,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/power_avg.sv
// power_avg
//   Spectral power averager: |X|^2 = re^2 + im^2 per bin, summed per bin over
//   2^LOG_AVG frames in RAM, emitted as sum >> LOG_AVG on the last frame.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for i_vld & i_sof; every other sample is ignored
//   ACC   | framed; samples accepted in bin order, framing checked per sample
//
// Ports:
//   clk     in   clock, rising edge
//   rstn    in   asynchronous active-low reset
//   i_re    in   signed real part of bin
//   i_im    in   signed imaginary part of bin
//   i_vld   in   bin valid (gaps allowed)
//   i_sof   in   with i_vld: sample is bin 0 of a frame
//   o_data  out  averaged power, bin-ordered, held when o_vld = 0
//   o_vld   out  o_data valid
//   o_sof   out  with o_vld: bin 0 of an averaged frame
//   o_err   out  one-cycle framing error pulse
//
// Latency: sample taken at edge k -> o_vld after edge k+3
//   k   : S1 squares, address, flags
//   k+1 : S2 power sum; RAM read of S1 address returns
//   k+2 : S3 new accumulator registered and written back
//   k+3 : output registers
module power_avg
  import power_avg_pkg::*;
#(
  parameter int W_DATA  = 16,
  parameter int N_FFT   = 1024,
  parameter int LOG_AVG = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [W_DATA-1:0]     i_re,
  input  logic [W_DATA-1:0]     i_im,
  input  logic                  i_vld,
  input  logic                  i_sof,
  output logic [2*W_DATA-1:0]   o_data,
  output logic                  o_vld,
  output logic                  o_sof,
  output logic                  o_err
);

  localparam int P_W   = 2 * W_DATA;
  localparam int ACC_W = acc_width(W_DATA, LOG_AVG);
  localparam int BIN_W = cnt_width(N_FFT);
  localparam int FRM_W = cnt_width(1 << LOG_AVG);

  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(N_FFT - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'((1 << LOG_AVG) - 1);

  state_t state, state_nxt;
  logic [BIN_W-1:0] bin_cnt, bin_nxt, t_bin;
  logic [FRM_W-1:0] frm_cnt, frm_nxt, t_frm;
  logic take, err_c;

  // ---------------- framing FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bin_cnt <= '0;
      frm_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bin_cnt <= bin_nxt;
      frm_cnt <= frm_nxt;
    end
  end

  // t_bin / t_frm are the bin and frame the accepted sample is booked under;
  // they differ from the counters only when a frame restarts.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    err_c     = 1'b0;
    t_bin     = bin_cnt;
    t_frm     = frm_cnt;
    bin_nxt   = bin_cnt;
    frm_nxt   = frm_cnt;
    unique case (state)
      IDLE: begin
        if (i_vld && i_sof) begin
          take      = 1'b1;
          t_bin     = '0;
          t_frm     = '0;
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (i_vld) begin
          if (bin_cnt == '0 && !i_sof) begin
            // Lost frame alignment: drop the sample and resynchronise.
            err_c     = 1'b1;
            frm_nxt   = '0;
            state_nxt = IDLE;
          end else if (bin_cnt != '0 && i_sof) begin
            // Early frame start: restart the average from this sample.
            err_c = 1'b1;
            take  = 1'b1;
            t_bin = '0;
            t_frm = '0;
          end else begin
            take = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      if (t_bin == BIN_LAST) begin
        bin_nxt = '0;
        frm_nxt = (t_frm == FRM_LAST) ? '0 : t_frm + 1'b1;
      end else begin
        bin_nxt = t_bin + 1'b1;
        frm_nxt = t_frm;
      end
    end
  end

  // ---------------- S1: squares ----------------
  logic signed [P_W-1:0] re_x, im_x;
  logic        [P_W-1:0] re_sq_c, im_sq_c;

  assign re_x    = $signed({{W_DATA{i_re[W_DATA-1]}}, i_re});
  assign im_x    = $signed({{W_DATA{i_im[W_DATA-1]}}, i_im});
  // Each square is at most 2^(2*W_DATA-2), so the signed product is exact.
  assign re_sq_c = re_x * re_x;
  assign im_sq_c = im_x * im_x;

  logic             s1_vld, s1_first, s1_last, s1_sof;
  logic [BIN_W-1:0] s1_addr;
  logic [P_W-1:0]   s1_re_sq, s1_im_sq;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_sof   <= 1'b0;
      s1_addr  <= '0;
      s1_re_sq <= '0;
      s1_im_sq <= '0;
    end else begin
      s1_vld <= take;
      if (take) begin
        s1_first <= (t_frm == '0);
        s1_last  <= (t_frm == FRM_LAST);
        s1_sof   <= (t_bin == '0);
        s1_addr  <= t_bin;
        s1_re_sq <= re_sq_c;
        s1_im_sq <= im_sq_c;
      end
    end
  end

  // ---------------- S2: power, RAM read returns ----------------
  logic             s2_vld, s2_first, s2_last, s2_sof;
  logic [BIN_W-1:0] s2_addr;
  logic [P_W-1:0]   s2_p;
  logic [ACC_W-1:0] ram_rd, acc_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld   <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sof   <= 1'b0;
      s2_addr  <= '0;
      s2_p     <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_sof   <= s1_sof;
        s2_addr  <= s1_addr;
        s2_p     <= s1_re_sq + s1_im_sq;
      end
    end
  end

  // First frame of a run ignores the RAM, so stale contents never leak in.
  assign acc_nxt = s2_first ? ACC_W'(s2_p) : ram_rd + ACC_W'(s2_p);

  power_avg_sdp_ram #(
    .DEPTH (N_FFT),
    .WIDTH (ACC_W),
    .AW    (BIN_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (s2_vld),
    .wr_addr (s2_addr),
    .wr_data (acc_nxt),
    .rd_en   (s1_vld),
    .rd_addr (s1_addr),
    .rd_data (ram_rd)
  );

  // ---------------- S3: accumulator ----------------
  logic           s3_vld, s3_last, s3_sof;
  logic [P_W-1:0] s3_avg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_vld  <= 1'b0;
      s3_last <= 1'b0;
      s3_sof  <= 1'b0;
      s3_avg  <= '0;
    end else begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_last <= s2_last;
        s3_sof  <= s2_sof;
        s3_avg  <= acc_nxt[ACC_W-1:LOG_AVG];
      end
    end
  end

  // ---------------- outputs ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_data <= '0;
      o_vld  <= 1'b0;
      o_sof  <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_vld <= s3_vld & s3_last;
      o_sof <= s3_vld & s3_last & s3_sof;
      o_err <= err_c;
      if (s3_vld && s3_last) o_data <= s3_avg;
    end
  end

endmodule

// File: tb/tb_power_avg.sv
module tb_power_avg;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // instance a: N_FFT = 8, LOG_AVG = 2; instance b: N_FFT = 8, LOG_AVG = 0
  logic [15:0] a_re, a_im, b_re, b_im;
  logic        a_vld, a_sof, b_vld, b_sof;
  logic [31:0] a_data, b_data;
  logic        a_ovld, a_osof, a_oerr, b_ovld, b_osof, b_oerr;

  power_avg #(.W_DATA(16), .N_FFT(8), .LOG_AVG(2)) dut_a (
    .clk(clk), .rstn(rstn), .i_re(a_re), .i_im(a_im), .i_vld(a_vld), .i_sof(a_sof),
    .o_data(a_data), .o_vld(a_ovld), .o_sof(a_osof), .o_err(a_oerr));

  power_avg #(.W_DATA(16), .N_FFT(8), .LOG_AVG(0)) dut_b (
    .clk(clk), .rstn(rstn), .i_re(b_re), .i_im(b_im), .i_vld(b_vld), .i_sof(b_sof),
    .o_data(b_data), .o_vld(b_ovld), .o_sof(b_osof), .o_err(b_oerr));

  typedef struct {
    logic [31:0] data;
    logic        sof;
    int          cyc;
  } exp_t;

  exp_t qa[$], qb[$];
  int   ea[$], eb[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  bit   gap_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    exp_t e;
    int   ec;
    if (a_ovld) begin
      chk("a_out_expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_data", 64'(a_data), 64'(e.data));
        chk("a_sof", 64'(a_osof), 64'(e.sof));
        chk("a_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (a_oerr) begin
      chk("a_err_expected", 64'(ea.size() != 0), 64'd1);
      if (ea.size() != 0) begin
        ec = ea.pop_front();
        chk("a_err_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    int   ec;
    if (b_ovld) begin
      chk("b_out_expected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_data", 64'(b_data), 64'(e.data));
        chk("b_sof", 64'(b_osof), 64'(e.sof));
        chk("b_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (b_oerr) begin
      chk("b_err_expected", 64'(eb.size() != 0), 64'd1);
      if (eb.size() != 0) begin
        ec = eb.pop_front();
        chk("b_err_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_vld = 1'b0; a_sof = 1'b0;
      b_vld = 1'b0; b_sof = 1'b0;
    end
  endtask

  // One sample; captured at the next rising edge (cyc+1). An expected output
  // is due three edges later, an expected error pulse right after capture.
  task automatic send(input bit sel, input int re, input int im, input logic sof,
                      input bit emit, input logic [31:0] ev, input bit exp_err);
    int   g;
    exp_t e;
    if (gap_en) begin
      g = $urandom_range(0, 1);
      idle(g);
    end
    @(negedge clk);
    if (sel) begin
      b_re = 16'(re); b_im = 16'(im); b_vld = 1'b1; b_sof = sof;
      a_vld = 1'b0; a_sof = 1'b0;
    end else begin
      a_re = 16'(re); a_im = 16'(im); a_vld = 1'b1; a_sof = sof;
      b_vld = 1'b0; b_sof = 1'b0;
    end
    e.data = ev; e.sof = sof; e.cyc = cyc + 4;
    if (emit) begin
      if (sel) qb.push_back(e); else qa.push_back(e);
    end
    if (exp_err) begin
      if (sel) eb.push_back(cyc + 1); else ea.push_back(cyc + 1);
    end
  endtask

  task automatic frame(input bit sel, input int re, input int im,
                       input bit emit, input logic [31:0] ev);
    for (int b = 0; b < 8; b++) send(sel, re, im, (b == 0), emit, ev, 1'b0);
  endtask

  task automatic drain(input string name);
    idle(1);
    for (int i = 0; i < 40 && (qa.size() + qb.size() + ea.size() + eb.size()) != 0; i++)
      @(negedge clk);
    idle(8);
    chk(name, 64'(qa.size() + qb.size() + ea.size() + eb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    rstn = 1'b0;
    a_re = '0; a_im = '0; a_vld = 1'b0; a_sof = 1'b0;
    b_re = '0; b_im = '0; b_vld = 1'b0; b_sof = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a_data", 64'(a_data), 64'd0);
    chk("reset_a_ctrl", 64'({a_ovld, a_osof, a_oerr}), 64'd0);
    chk("reset_b_data", 64'(b_data), 64'd0);
    chk("reset_b_ctrl", 64'({b_ovld, b_osof, b_oerr}), 64'd0);
    rstn = 1'b1;
    idle(2);

    // 1: 3^2 + 4^2 = 25 on every bin, only in the fourth frame
    repeat (3) frame(0, 3, 4, 0, 32'd0);
    frame(0, 3, 4, 1, 32'd25);
    drain("t1_drain");

    // 2: full-scale negative: 4 * 2^31 >> 2 = 0x8000_0000, then (1+1+1+4)>>2 = 1
    repeat (3) frame(0, -32768, -32768, 0, 32'd0);
    frame(0, -32768, -32768, 1, 32'h8000_0000);
    repeat (3) frame(0, 1, 0, 0, 32'd0);
    frame(0, 2, 0, 1, 32'd1);
    drain("t2_drain");

    // 3: early i_sof at bin 5 restarts; fresh run 4,16,36,64 -> 120>>2 = 30
    frame(0, 100, 0, 0, 32'd0);
    for (int b = 0; b < 5; b++) send(0, 100, 0, (b == 0), 0, 32'd0, 0);
    send(0, 2, 0, 1'b1, 0, 32'd0, 1'b1);
    for (int b = 1; b < 8; b++) send(0, 2, 0, 1'b0, 0, 32'd0, 0);
    frame(0, 4, 0, 0, 32'd0);
    frame(0, 6, 0, 0, 32'd0);
    frame(0, 8, 0, 1, 32'd30);
    drain("t3_drain");

    // 4: scenario 1 with random input gaps
    gap_en = 1'b1;
    repeat (3) frame(0, 3, 4, 0, 32'd0);
    frame(0, 3, 4, 1, 32'd25);
    gap_en = 1'b0;
    drain("t4_drain");

    // 5: async reset mid-frame 3, stream without i_sof ignored, fresh average 100
    frame(0, 100, 0, 0, 32'd0);
    frame(0, 100, 0, 0, 32'd0);
    for (int b = 0; b < 4; b++) send(0, 100, 0, (b == 0), 0, 32'd0, 0);
    idle(1);
    chk("t5_pre_reset_hold", 64'(a_data), 64'd25);
    #2 rstn = 1'b0;
    #1;
    chk("t5_async_data", 64'(a_data), 64'd0);
    chk("t5_async_ctrl", 64'({a_ovld, a_osof, a_oerr}), 64'd0);
    idle(2);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) send(0, 100, 0, 1'b0, 0, 32'd0, 0);
    repeat (3) frame(0, 6, 8, 0, 32'd0);
    frame(0, 6, 8, 1, 32'd100);
    drain("t5_drain");

    // 6: LOG_AVG = 0 pass-through: 25 + 144 = 169, missing i_sof -> error + IDLE
    frame(1, -5, 12, 1, 32'd169);
    send(1, -5, 12, 1'b0, 0, 32'd0, 1'b1);
    for (int b = 1; b < 8; b++) send(1, -5, 12, 1'b0, 0, 32'd0, 0);
    frame(1, 3, 4, 1, 32'd25);
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/power_avg.md
# power_avg

Spectral power averager in the FFT post-processing chain. It takes complex FFT bins and computes |X|² = re² + im² per bin. It accumulates that value per bin over 2^LOG_AVG consecutive frames in an internal RAM, then emits the averaged power stream. Its 2·W_DATA-bit output feeds the convergent-rounding stage directly downstream, which cuts it to the final output width.

## Interface
Parameters:
- W_DATA, 16: signed width of input re/im (two's complement).
- N_FFT, 1024: bins per frame; power of two, ≥ 4.
- LOG_AVG, 2: log2 of frames averaged; 0 gives a per-frame pass-through.

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- i_re  in  W_DATA  signed real part of bin.
- i_im  in  W_DATA  signed imaginary part of bin.
- i_vld  in  1  bin valid; gaps allowed.
- i_sof  in  1  qualifies i_vld: this sample is bin 0 of a frame.
- o_data  out  2·W_DATA  unsigned averaged power, bin-ordered.
- o_vld  out  1  o_data valid.
- o_sof  out  1  with o_vld: bin 0 of an averaged frame.
- o_err  out  1  one-cycle pulse on a framing error.

## Operation
- Widths:
  - P = re² + im², 2·W_DATA bits unsigned; max 2^(2·W_DATA−1), no overflow.
  - Accumulator: 2·W_DATA + LOG_AVG bits, never saturates.
  - Output = acc >> LOG_AVG (truncation; rounding is downstream's job).
- Counters:
  - bin_cnt: 0..N_FFT−1, wraps to 0.
  - frm_cnt: 0..2^LOG_AVG−1, increments when bin N_FFT−1 is accepted, wraps to 0.
- State machine, enum with two states:
  - IDLE: all i_vld ignored until i_vld & i_sof. That sample is accepted as bin 0 of frame 0. Go to ACC.
  - ACC, accepted sample at bin_cnt 0 with i_sof = 1: normal frame start.
  - ACC, sample at bin_cnt 0 with i_sof = 0: o_err pulse, sample dropped, frm_cnt ← 0, go to IDLE.
  - ACC, i_sof = 1 at bin_cnt ≠ 0: o_err pulse. Sample is taken as bin 0 of a fresh frame 0; bin_cnt, frm_cnt restart and the partial average is discarded. Stay in ACC.
- Per accepted sample, RAM address = bin_cnt:
  - frm_cnt = 0: acc = P. Old RAM content is not read, so RAM needs no reset.
  - otherwise: acc = RAM[bin] + P.
  - acc is written back to RAM[bin].
  - If frm_cnt = 2^LOG_AVG−1: emit o_data = acc >> LOG_AVG, o_vld = 1, o_sof = (bin = 0).
- RAM read-during-write hazard cannot occur: the same address recurs no sooner than N_FFT ≥ 4 accepted samples later, and the pipeline is 3 deep.
- Reset mid-operation: state → IDLE, counters and pipeline valids cleared, outputs to reset values. RAM contents are stale but harmless, per the frm_cnt = 0 rule above.

## Timing
- Reset values: o_data = 0, o_vld = 0, o_sof = 0, o_err = 0, state IDLE, bin_cnt = 0, frm_cnt = 0.
- Pipeline, each stage carrying its own valid/sof/first/last flags:
  - S1: register re², im²; issue RAM read.
  - S2: register P; RAM data returns (1-cycle synchronous read).
  - S3: register acc, write RAM, drive outputs.
- Latency: sample at edge k → o_vld high after edge k+3. Fixed and independent of input gaps.
- Throughput: one bin per cycle; no backpressure. The downstream stage accepts every o_vld.
- o_err: asserted the cycle after the offending sample edge, for exactly one cycle.
- o_data holds its last value when o_vld = 0.

## Structure
- Package power_avg_pkg:
  - state enum (IDLE, ACC);
  - localparam helpers for accumulator width and counter widths ($clog2(N_FFT), LOG_AVG).
- Sub-module sdp_ram:
  - simple dual-port, depth N_FFT, width 2·W_DATA + LOG_AVG;
  - one write port, one registered read port, no reset.
- Top holds the FSM, counters, squarer/adder pipeline and output registers.

## Test plan
1. N_FFT = 8, LOG_AVG = 2; four contiguous frames, every bin re = 3, im = 4 → eight outputs of 25 only during frame 4; o_sof on the first; first o_vld 3 cycles after frame-4 bin 0.
2. Same config, all bins re = im = −32768 → outputs 0x8000_0000 with no wrap. Then bins re = 1, im = 0 in frames 1–3 and re = 2, im = 0 in frame 4 → (1+1+1+4) >> 2 = 1.
3. i_sof at bin 5 of frame 2 → single o_err pulse; no output until four further complete frames; first averaged result then equals those frames only.
4. Scenario 1 with random i_vld gaps (about 50 % duty) → identical o_data sequence; each o_vld exactly 3 cycles after its frame-4 input sample.
5. rstn low asynchronously mid-frame 3, for 2 cycles → outputs 0 immediately, without a clock edge. After release, the i_vld stream without i_sof is ignored. Output appears only after four fresh frames, with correct values despite stale RAM.
6. LOG_AVG = 0; bins re = −5, im = 12 → every frame outputs 169 per bin; o_sof every bin 0. Missing i_sof on the second frame's bin 0 → o_err pulse, then IDLE until the next i_sof.
